wg_done_collector: RTL and testbench
====================================

Name: wg_done_collector

Overview:
- Sits directly downstream of the per-CU handler blocks.
- Accepts wg-done notifications from NUM_CU handlers over their valid/ack interface and arbitrates between them round-robin.
- Queues accepted notifications in a small FIFO and presents them to the host interface over valid/ready.
- Emits a one-cycle free pulse to the allocator so it can release the WG's resources.

Parameters:
NUM_CU, 4, number of CU handlers served
CU_ID_WIDTH, 2, width of CU index, equals clog2(NUM_CU)
WG_ID_WIDTH, 15, workgroup id width
FIFO_DEPTH, 4, completion queue entries, power of two, at least 2
FIFO_ADDR_WIDTH, 2, equals clog2(FIFO_DEPTH)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
cu_wg_done_valid_i  input  NUM_CU  per-CU done valid; held until acked
cu_wg_done_wg_id_i  input  NUM_CU*WG_ID_WIDTH  per-CU wg id; CU k at bits [k*WG_ID_WIDTH +: WG_ID_WIDTH]
cu_wg_done_ack_o  output  NUM_CU  one-cycle ack per CU
host_wg_done_valid_o  output  1  FIFO head valid
host_wg_done_wg_id_o  output  WG_ID_WIDTH  head wg id
host_wg_done_cu_id_o  output  CU_ID_WIDTH  head CU index
host_wg_done_ready_i  input  1  host accepts head
alloc_wg_free_valid_o  output  1  one-cycle resource-release pulse
alloc_wg_free_cu_id_o  output  CU_ID_WIDTH  CU being freed
alloc_wg_free_wg_id_o  output  WG_ID_WIDTH  WG being freed
fifo_count_o  output  FIFO_ADDR_WIDTH+1  occupancy, for debug and perf counters

Behaviour:
- Reset: all outputs 0, FIFO empty, count 0, round-robin pointer = NUM_CU-1 (so CU0 has first priority). Reset mid-operation discards queued entries and pending acks. Upstream handlers stay in their propagate state and are re-served after reset.
- Eligibility: req[k] = cu_wg_done_valid_i[k] & ~cu_wg_done_ack_o[k]. The mask is required because a handler's valid stays high during its ack cycle and drops one cycle later; without it the same WG would be captured twice.
- Grant (combinational): only when count < FIFO_DEPTH, or count == FIFO_DEPTH with a pop in the same cycle. Picks the first req starting at pointer+1 and wrapping modulo NUM_CU. At most one grant per cycle.
- Grant in cycle T produces these effects at the T edge:
  - push {cu_id, wg_id};
  - pointer <= granted index;
  - ack_o[k] <= 1 for cycle T+1 only;
  - alloc_wg_free_valid_o <= 1 for cycle T+1, carrying the same cu_id and wg_id.
- ack_o and free outputs are registered. All ack bits other than the granted one are 0.
- FIFO: circular, with read and write pointers wrapping at FIFO_DEPTH.
  - host_wg_done_valid_o = count != 0, with the head presented directly from storage.
  - Pop when valid & ready. Head data is stable while valid & ~ready.
  - Latency: grant in cycle T into an empty FIFO gives host valid in T+1.
- Simultaneous push and pop: count unchanged; allowed at full (frees the slot in the same cycle) and at empty+1.
- Full with no pop: no grant, no ack. Handlers keep valid asserted and wait; nothing is dropped.
- ready while empty: ignored; count never underflows.
- Width rules: count is FIFO_ADDR_WIDTH+1 bits and saturates by construction at FIFO_DEPTH.
- Pointer wrap: pointer wraps NUM_CU-1 -> 0. NUM_CU is not required to be a power of two; wrap is explicit.

Test Plan:
- Single done: CU2 valid, wg_id=0x1A3, ready=1 -> ack[2] high exactly 1 cycle at T+1; free pulse T+1 with cu=2, wg=0x1A3; host valid T+1 with cu=2, wg=0x1A3; popped the same cycle; count returns to 0.
- All four CUs valid from reset, with wg ids 10,11,12,13 and ready=1 -> grants and host order cu0,1,2,3 in consecutive cycles; each ack is 1 cycle; no duplicate entries.
- Fairness: CU0 reasserts valid immediately after each ack while CU3 stays valid -> order alternates 0,3,0,3; CU3 is never starved.
- Backpressure: ready=0, 6 CUs' worth of requests (NUM_CU=4 plus re-requests) -> count reaches 4, no further acks, waiting valids stay high. Raising ready for 1 cycle -> pop and push in the same cycle, count stays 4, and the oldest entry leaves first.
- Held valid: handler holds valid through its ack cycle -> exactly one FIFO entry and one free pulse.
- Reset mid-operation: rst for 1 cycle with count=3 and an ack pending -> next cycle all outputs 0, count 0, pointer back so CU0 wins the next contention.

Source files
------------

// File: rtl/wg_done_collector.sv
// Collects wg-done notifications from per-CU handlers, arbitrates round-robin,
// queues them for the host and pulses the allocator to free the WG's resources.
module wg_done_collector #(
   parameter int unsigned NUM_CU          = 4,
   parameter int unsigned CU_ID_WIDTH     = 2,
   parameter int unsigned WG_ID_WIDTH     = 15,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned FIFO_ADDR_WIDTH = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CU-1:0]             cu_wg_done_valid_i,
   input  logic [NUM_CU*WG_ID_WIDTH-1:0] cu_wg_done_wg_id_i,
   output logic [NUM_CU-1:0]             cu_wg_done_ack_o,
   output logic                          host_wg_done_valid_o,
   output logic [WG_ID_WIDTH-1:0]        host_wg_done_wg_id_o,
   output logic [CU_ID_WIDTH-1:0]        host_wg_done_cu_id_o,
   input  logic                          host_wg_done_ready_i,
   output logic                          alloc_wg_free_valid_o,
   output logic [CU_ID_WIDTH-1:0]        alloc_wg_free_cu_id_o,
   output logic [WG_ID_WIDTH-1:0]        alloc_wg_free_wg_id_o,
   output logic [FIFO_ADDR_WIDTH:0]      fifo_count_o
);

   localparam int unsigned CNT_W = FIFO_ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CU_ID_WIDTH-1:0] LAST_CU = CU_ID_WIDTH'(NUM_CU - 1);

   typedef struct packed {
      logic [CU_ID_WIDTH-1:0] cu_id;
      logic [WG_ID_WIDTH-1:0] wg_id;
   } entry_t;

   entry_t                     mem [FIFO_DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
   logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
   logic [CU_ID_WIDTH-1:0]     rr_ptr;
   logic [WG_ID_WIDTH-1:0]     wg_arr [NUM_CU];

   logic [NUM_CU-1:0]          req;
   logic                       pop;
   logic                       can_push;
   logic                       grant;
   logic [CU_ID_WIDTH-1:0]     gnt_idx;
   logic [CU_ID_WIDTH-1:0]     cand_idx;
   int unsigned                cand;

   for (genvar k = 0; k < NUM_CU; k++) begin : g_unpack
      assign wg_arr[k] = cu_wg_done_wg_id_i[k*WG_ID_WIDTH +: WG_ID_WIDTH];
   end

   // Masking with ack keeps a handler's held valid from being captured twice.
   assign req                  = cu_wg_done_valid_i & ~cu_wg_done_ack_o;
   assign host_wg_done_valid_o = (fifo_count_o != '0);
   assign host_wg_done_cu_id_o = mem[rd_ptr].cu_id;
   assign host_wg_done_wg_id_o = mem[rd_ptr].wg_id;
   assign pop                  = host_wg_done_valid_o & host_wg_done_ready_i;
   assign can_push             = (fifo_count_o != DEPTH_C) | pop;

   // Round-robin search starting after the last granted CU, explicit wrap.
   always_comb begin
      grant    = 1'b0;
      gnt_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned i = 1; i <= NUM_CU; i++) begin
         cand = 32'(rr_ptr) + i;
         if (cand >= NUM_CU) cand = cand - NUM_CU;
         cand_idx = CU_ID_WIDTH'(cand);
         if (!grant && can_push && req[cand_idx]) begin
            grant   = 1'b1;
            gnt_idx = cand_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr                <= '0;
         rd_ptr                <= '0;
         rr_ptr                <= LAST_CU;
         fifo_count_o          <= '0;
         cu_wg_done_ack_o      <= '0;
         alloc_wg_free_valid_o <= 1'b0;
         alloc_wg_free_cu_id_o <= '0;
         alloc_wg_free_wg_id_o <= '0;
      end else begin
         cu_wg_done_ack_o      <= '0;
         alloc_wg_free_valid_o <= 1'b0;
         if (grant) begin
            mem[wr_ptr]                <= '{cu_id: gnt_idx, wg_id: wg_arr[gnt_idx]};
            wr_ptr                     <= wr_ptr + FIFO_ADDR_WIDTH'(1);
            rr_ptr                     <= gnt_idx;
            cu_wg_done_ack_o[gnt_idx]  <= 1'b1;
            alloc_wg_free_valid_o      <= 1'b1;
            alloc_wg_free_cu_id_o      <= gnt_idx;
            alloc_wg_free_wg_id_o      <= wg_arr[gnt_idx];
         end
         if (pop) rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
         case ({grant, pop})
            2'b10:   fifo_count_o <= fifo_count_o + CNT_W'(1);
            2'b01:   fifo_count_o <= fifo_count_o - CNT_W'(1);
            default: fifo_count_o <= fifo_count_o;
         endcase
      end
   end

endmodule

// File: tb/tb_wg_done_collector.sv
// Directed bench for wg_done_collector: cycle vector table plus a reactive
// fairness sequence with two handlers re-requesting after every ack.
module tb_wg_done_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  valid;
   logic [59:0] wg_in;
   logic        ready;
   logic [3:0]  ack;
   logic        hv;
   logic [14:0] hwg;
   logic [1:0]  hcu;
   logic        fv;
   logic [1:0]  fcu;
   logic [14:0] fwg;
   logic [2:0]  cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   wg_done_collector dut (
      .clk                   (clk),
      .rst                   (rst),
      .cu_wg_done_valid_i    (valid),
      .cu_wg_done_wg_id_i    (wg_in),
      .cu_wg_done_ack_o      (ack),
      .host_wg_done_valid_o  (hv),
      .host_wg_done_wg_id_o  (hwg),
      .host_wg_done_cu_id_o  (hcu),
      .host_wg_done_ready_i  (ready),
      .alloc_wg_free_valid_o (fv),
      .alloc_wg_free_cu_id_o (fcu),
      .alloc_wg_free_wg_id_o (fwg),
      .fifo_count_o          (cnt)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [59:0] wg;
      logic        ready;
      logic [3:0]  ack;
      logic        fv;
      logic [1:0]  fcu;
      logic [14:0] fwg;
      logic        hv;
      logic [1:0]  hcu;
      logic [14:0] hwg;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [59:0] pk(input int a, input int b, input int c, input int d);
      return {15'(d), 15'(c), 15'(b), 15'(a)};
   endfunction

   task automatic add(input logic r, input logic [3:0] v, input logic [59:0] w, input logic rd,
                      input logic [3:0] a, input logic f, input int fc, input int fw,
                      input logic h, input int hc, input int hw, input int c);
      vec_t e;
      e.rst = r; e.valid = v; e.wg = w; e.ready = rd; e.ack = a;
      e.fv = f; e.fcu = 2'(fc); e.fwg = 15'(fw);
      e.hv = h; e.hcu = 2'(hc); e.hwg = 15'(hw); e.cnt = 3'(c);
      vecs.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   int          npulse;
   int          id0;
   int          id3;
   bit          seen0;
   bit          seen3;
   int          exp_cu;
   int          exp_wg;

   initial begin
      rst = 1'b1; valid = '0; wg_in = '0; ready = 1'b0;

      // single done, held valid through ack, ready while empty
      add(1, 4'b0000, pk(0,0,0,0), 0,       4'b0000, 0,0,0,      0,0,0,      0);
      add(0, 4'b0100, pk(0,0,'h1A3,0), 1,   4'b0100, 1,2,'h1A3,  1,2,'h1A3,  1);
      add(0, 4'b0100, pk(0,0,'h1A3,0), 1,   4'b0000, 0,0,0,      0,0,0,      0);
      add(0, 4'b0000, pk(0,0,'h1A3,0), 1,   4'b0000, 0,0,0,      0,0,0,      0);
      // all four CUs from reset, ready high
      add(1, 4'b1111, pk(10,11,12,13), 1,   4'b0000, 0,0,0,      0,0,0,      0);
      add(0, 4'b1111, pk(10,11,12,13), 1,   4'b0001, 1,0,10,     1,0,10,     1);
      add(0, 4'b1111, pk(10,11,12,13), 1,   4'b0010, 1,1,11,     1,1,11,     1);
      add(0, 4'b1110, pk(10,11,12,13), 1,   4'b0100, 1,2,12,     1,2,12,     1);
      add(0, 4'b1100, pk(10,11,12,13), 1,   4'b1000, 1,3,13,     1,3,13,     1);
      add(0, 4'b1000, pk(10,11,12,13), 1,   4'b0000, 0,0,0,      0,0,0,      0);
      add(0, 4'b0000, pk(10,11,12,13), 1,   4'b0000, 0,0,0,      0,0,0,      0);
      // backpressure: fill to 4, re-requests wait, one-cycle ready
      add(0, 4'b1111, pk(20,21,22,23), 0,   4'b0001, 1,0,20,     1,0,20,     1);
      add(0, 4'b1111, pk(20,21,22,23), 0,   4'b0010, 1,1,21,     1,0,20,     2);
      add(0, 4'b1111, pk(24,21,22,23), 0,   4'b0100, 1,2,22,     1,0,20,     3);
      add(0, 4'b1111, pk(24,25,22,23), 0,   4'b1000, 1,3,23,     1,0,20,     4);
      add(0, 4'b1111, pk(24,25,26,23), 0,   4'b0000, 0,0,0,      1,0,20,     4);
      add(0, 4'b1111, pk(24,25,26,27), 0,   4'b0000, 0,0,0,      1,0,20,     4);
      add(0, 4'b1111, pk(24,25,26,27), 1,   4'b0001, 1,0,24,     1,1,21,     4);
      add(0, 4'b1111, pk(24,25,26,27), 0,   4'b0000, 0,0,0,      1,1,21,     4);
      add(0, 4'b1111, pk(28,25,26,27), 1,   4'b0010, 1,1,25,     1,2,22,     4);
      // reset mid-operation with count 3 and an ack pending
      add(1, 4'b0110, pk(0,31,32,0), 0,     4'b0000, 0,0,0,      0,0,0,      0);
      add(0, 4'b0110, pk(0,31,32,0), 0,     4'b0010, 1,1,31,     1,1,31,     1);
      add(0, 4'b0110, pk(0,31,32,0), 0,     4'b0100, 1,2,32,     1,1,31,     2);
      add(0, 4'b0110, pk(0,33,32,0), 0,     4'b0010, 1,1,33,     1,1,31,     3);
      add(1, 4'b1111, pk(40,41,42,43), 1,   4'b0000, 0,0,0,      0,0,0,      0);
      add(0, 4'b1111, pk(40,41,42,43), 1,   4'b0001, 1,0,40,     1,0,40,     1);
      add(0, 4'b1111, pk(40,41,42,43), 1,   4'b0010, 1,1,41,     1,1,41,     1);

      @(posedge clk); #1;
      foreach (vecs[i]) begin
         rst = vecs[i].rst; valid = vecs[i].valid; wg_in = vecs[i].wg; ready = vecs[i].ready;
         @(posedge clk); #1;
         chk($sformatf("v%0d.ack", i), 32'(ack), 32'(vecs[i].ack));
         chk($sformatf("v%0d.free_valid", i), 32'(fv), 32'(vecs[i].fv));
         chk($sformatf("v%0d.host_valid", i), 32'(hv), 32'(vecs[i].hv));
         chk($sformatf("v%0d.count", i), 32'(cnt), 32'(vecs[i].cnt));
         if (vecs[i].fv || vecs[i].rst) begin
            chk($sformatf("v%0d.free_cu", i), 32'(fcu), 32'(vecs[i].fcu));
            chk($sformatf("v%0d.free_wg", i), 32'(fwg), 32'(vecs[i].fwg));
         end
         if (vecs[i].hv || vecs[i].rst) begin
            chk($sformatf("v%0d.host_cu", i), 32'(hcu), 32'(vecs[i].hcu));
            chk($sformatf("v%0d.host_wg", i), 32'(hwg), 32'(vecs[i].hwg));
         end
      end

      // fairness: CU0 and CU3 re-request right after each ack; grants must alternate
      rst = 1'b1; valid = '0; ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      id0 = 100; id3 = 300; seen0 = 0; seen3 = 0; npulse = 0;
      valid = 4'b1001; wg_in = pk(id0, 0, 0, id3);
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         chk("fair.ack_onehot", 32'($countones(ack) <= 1), 32'd1);
         chk("fair.free_vs_host", 32'(fv), 32'(hv));
         if (fv) begin
            exp_cu = (npulse % 2 == 0) ? 0 : 3;
            exp_wg = (exp_cu == 0 ? 100 : 300) + npulse / 2;
            chk("fair.free_cu", 32'(fcu), 32'(exp_cu));
            chk("fair.free_wg", 32'(fwg), 32'(exp_wg));
            chk("fair.host_cu", 32'(hcu), 32'(exp_cu));
            chk("fair.host_wg", 32'(hwg), 32'(exp_wg));
            npulse++;
         end
         if (seen0) begin id0++; seen0 = 0; end
         if (seen3) begin id3++; seen3 = 0; end
         if (ack[0]) seen0 = 1;
         if (ack[3]) seen3 = 1;
         wg_in = pk(id0, 0, 0, id3);
      end
      chk("fair.pulses", 32'(npulse), 32'd12);
      valid = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("fair.drain_count", 32'(cnt), 32'd0);
      chk("fair.drain_host_valid", 32'(hv), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
